// File: rtl/debounce_pkg.sv
// Shared debouncer constants: FSM state encodings and board-level default timing.
package debounce_pkg;

   localparam logic [1:0] IDLE_LOW  = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] IDLE_HIGH = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   localparam int DEF_STABLE_CYCLES = 50000;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_CNT_W         = 16;

   function automatic logic state_is_wait(input logic [1:0] s);
      return (s == WAIT_HIGH) || (s == WAIT_LOW);
   endfunction

endpackage

// File: rtl/button_debouncer_sync_ff.sv
// Plain N-flop synchronizer for an asynchronous single-bit input; flops reset to 0.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Button conditioner: synchronizer plus debounce FSM; btn_clean changes only after a stable new level.
// Build option: DEBOUNCER_ACTIVE_LOW_EN inverts btn_raw ahead of the synchronizer.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   output logic       btn_clean,
   output logic       busy,
   output logic [1:0] dbg_state_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             btn_in;
   logic             btn_sync;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef DEBOUNCER_ACTIVE_LOW_EN
   assign btn_in = ~btn_raw;
`else
   assign btn_in = btn_raw;
`endif

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (btn_in),
      .q_o (btn_sync)
   );

   // Counter is cleared on every WAIT entry and parks at CNT_LAST, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE_LOW: begin
            if (btn_sync) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!btn_sync) begin
               state_d = IDLE_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE_HIGH: begin
            if (!btn_sync) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (btn_sync) begin
               state_d = IDLE_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_clean   = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
   assign busy        = state_is_wait(state_q);
   assign dbg_state_o = state_q;

endmodule
